// File: rtl/valid_pipe_credit_adapter.sv
// Credit-gated wrapper that puts a fixed-latency valid-only pipeline behind ready/valid streams.
// Optional sticky overflow flag: define VALID_PIPE_ADAPTER_OVF_CHECK_EN.
module valid_pipe_credit_adapter #(
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_LATENCY = 2,
  parameter int DEPTH        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  pipe_in_valid,
  input  logic                  pipe_out_valid,
  input  logic [DATA_WIDTH-1:0] pipe_out_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef VALID_PIPE_ADAPTER_OVF_CHECK_EN
  ,
  output logic                  ovf_err
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  if (PIPE_LATENCY < 1 || DEPTH < 1) begin : g_bad_cfg
    $error("valid_pipe_credit_adapter: PIPE_LATENCY and DEPTH must be >= 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         credits_used;

  logic issue;
  logic pop;
  logic wr;
  logic dec;

  assign s_ready       = !rst && (credits_used < FULL);
  assign issue         = s_valid && s_ready;
  assign pipe_in_valid = issue;
  assign m_valid       = !rst && (occupancy != '0);
  assign pop           = m_valid && m_ready;
  assign m_data        = mem[rd_ptr];

  // A full FIFO can still take a write if the head leaves this cycle.
  assign wr  = pipe_out_valid && ((occupancy != FULL) || pop);
  assign dec = pop && (credits_used != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      credits_used <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= pipe_out_data;
        wr_ptr      <= (wr_ptr == PLAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PLAST) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({wr, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      unique case ({issue, dec})
        2'b10:   credits_used <= credits_used + 1'b1;
        2'b01:   credits_used <= credits_used - 1'b1;
        default: credits_used <= credits_used;
      endcase
    end
  end

`ifdef VALID_PIPE_ADAPTER_OVF_CHECK_EN
  logic drop;
  logic underflow;

  assign drop      = pipe_out_valid && (occupancy == FULL) && !pop;
  assign underflow = pop && (credits_used == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (drop || underflow) begin
      ovf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_valid_pipe_credit_adapter.sv
// Bench for valid_pipe_credit_adapter: queue-based model checked every cycle,
// plus directed literal checks.
module tb_valid_pipe_credit_adapter;

  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic          pipe_in_valid;
  logic          pipe_out_valid;
  logic [DW-1:0] pipe_out_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef VALID_PIPE_ADAPTER_OVF_CHECK_EN
  logic          ovf_err;
`endif

  logic [DW-1:0] s_data;
  logic          force_v;
  logic [DW-1:0] force_d;
  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];

  logic [DW-1:0] q [$];
  bit            e_ovf;
  int            n_chk;
  int            n_fail;
  int            rcvd;

  valid_pipe_credit_adapter #(
    .DATA_WIDTH  (DW),
    .PIPE_LATENCY(LAT),
    .DEPTH       (DEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .pipe_in_valid (pipe_in_valid),
    .pipe_out_valid(pipe_out_valid),
    .pipe_out_data (pipe_out_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
`ifdef VALID_PIPE_ADAPTER_OVF_CHECK_EN
    ,
    .ovf_err       (ovf_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pipe_out_valid = pv[LAT-1] | force_v;
  assign pipe_out_data  = force_v ? force_d : pd[LAT-1];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Compare against the model at negedge, then advance the model past posedge.
  task automatic cycle();
    bit e_sr, e_mv, iss, pp;
    int inflight;
    @(negedge clk);
    inflight = 0;
    for (int i = 0; i < LAT; i++) inflight += int'(pv[i]);
    e_sr = !rst && (q.size() + inflight < DEP);
    e_mv = !rst && (q.size() != 0);
    iss  = s_valid && e_sr;
    pp   = e_mv && m_ready;
    chk("s_ready", DW'(s_ready), DW'(e_sr));
    chk("pipe_in_valid", DW'(pipe_in_valid), DW'(iss));
    chk("m_valid", DW'(m_valid), DW'(e_mv));
    if (e_mv) chk("m_data", m_data, q[0]);
`ifdef VALID_PIPE_ADAPTER_OVF_CHECK_EN
    if (!rst) chk("ovf_err", DW'(ovf_err), DW'(e_ovf));
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      e_ovf = 1'b0;
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
    end else begin
      if (pp) void'(q.pop_front());
      if (pipe_out_valid) begin
        if (q.size() == DEP) e_ovf = 1'b1;
        else q.push_back(pipe_out_data);
      end
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = iss;
      pd[0] = s_data;
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rcvd    = 0;
    e_ovf   = 1'b0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    force_v = 1'b0;
    force_d = '0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end

    cycle();
    settle();
    chk("rst_s_ready", DW'(s_ready), 0);
    chk("rst_m_valid", DW'(m_valid), 0);
    chk("rst_pipe_in_valid", DW'(pipe_in_valid), 0);
    cycle();
    rst = 1'b0;
    settle();
    chk("post_rst_s_ready", DW'(s_ready), 1);

    // single item
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    settle();
    chk("t0_pipe_in_valid", DW'(pipe_in_valid), 1);
    cycle();
    s_valid = 1'b0;
    cycle();
    cycle();
    m_ready = 1'b1;
    settle();
    chk("t3_m_valid", DW'(m_valid), 1);
    chk("t3_m_data", m_data, 32'hDEADBEEF);
    cycle();
    m_ready = 1'b0;
    settle();
    chk("t4_m_valid", DW'(m_valid), 0);

    // credit exhaustion
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      cycle();
    end
    s_data = 32'h99;
    settle();
    chk("exhaust_s_ready", DW'(s_ready), 0);
    for (int i = 0; i < 3; i++) cycle();
    settle();
    chk("full_head", m_data, 32'h1);
    chk("full_s_ready", DW'(s_ready), 0);

    // release
    s_valid = 1'b0;
    m_ready = 1'b1;
    cycle();
    settle();
    chk("release_s_ready", DW'(s_ready), 1);
    chk("release_head", m_data, 32'h2);
    s_valid = 1'b1;
    s_data  = 32'h5;
    cycle();
    m_ready = 1'b0;
    s_data  = 32'h6;
    settle();
    chk("after_swap_s_ready", DW'(s_ready), 1);
    cycle();
    s_valid = 1'b0;
    settle();
    chk("refull_s_ready", DW'(s_ready), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    settle();
    chk("drained_m_valid", DW'(m_valid), 0);

    // streaming 0..19
    begin
      int sent;
      sent = 0;
      for (int k = 0; k < 40 && (sent < 20 || m_valid); k++) begin
        s_valid = (sent < 20);
        s_data  = DW'(sent);
        m_ready = 1'b1;
        settle();
        if (sent < 20) chk("stream_s_ready", DW'(s_ready), 1);
        if (m_valid) begin
          chk("stream_order", m_data, DW'(rcvd));
          rcvd++;
        end
        if (s_valid && s_ready) sent++;
        cycle();
      end
      chk("stream_count", DW'(rcvd), 20);
    end

    // reset mid-flight
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hA0 + DW'(i);
      cycle();
    end
    rst = 1'b1;
    settle();
    chk("midrst_s_ready", DW'(s_ready), 0);
    chk("midrst_pipe_in_valid", DW'(pipe_in_valid), 0);
    chk("midrst_m_valid", DW'(m_valid), 0);
    cycle();
    rst     = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h55;
    settle();
    chk("postrst_m_valid", DW'(m_valid), 0);
    chk("postrst_s_ready", DW'(s_ready), 1);
    cycle();
    s_valid = 1'b0;
    cycle();
    cycle();
    settle();
    chk("postrst_item_valid", DW'(m_valid), 1);
    chk("postrst_item_data", m_data, 32'h55);
    m_ready = 1'b1;
    cycle();

`ifdef VALID_PIPE_ADAPTER_OVF_CHECK_EN
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hC0 + DW'(i);
      cycle();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    settle();
    chk("pre_ovf_flag", DW'(ovf_err), 0);
    force_v = 1'b1;
    force_d = 32'hBAD;
    cycle();
    force_v = 1'b0;
    settle();
    chk("ovf_set", DW'(ovf_err), 1);
    chk("ovf_head_kept", m_data, 32'hC0);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    settle();
    chk("ovf_sticky", DW'(ovf_err), 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    settle();
    chk("ovf_cleared", DW'(ovf_err), 0);
    cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
